// File: rtl/vt4_vram_pkg.sv
// Shared types and constants for the text VRAM arbiter and its clear engine.
package vt4_vram_pkg;

   localparam int ROW_W  = 5;
   localparam int COL_W  = 7;
   localparam int ADDR_W = 12;

   localparam int         DEF_ROWS      = 30;
   localparam int         DEF_COLS      = 100;
   localparam logic [7:0] DEF_FILL_CHAR = 8'h20;

   // VRAM address: row in the upper bits, column in the lower bits.
   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } vram_addr_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   // True when a {row, col} cell lies inside the visible text area.
   function automatic logic cell_in_range(
      input logic [ROW_W-1:0] row,
      input logic [COL_W-1:0] col,
      input logic [ROW_W-1:0] row_last,
      input logic [COL_W-1:0] col_last
   );
      return (row <= row_last) && (col <= col_last);
   endfunction

endpackage

// File: rtl/vram_clear_engine.sv
// Clear engine: walks one row or the whole screen, one fill write per free
// VRAM cycle, stalling whenever the video reader owns the port.
module vram_clear_engine
   import vt4_vram_pkg::*;
#(
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS
) (
   input  logic             clk,
   input  logic             reset_low,
   input  logic             vid_valid_i,
   input  logic             wr_valid_i,
   input  logic             clr_valid_i,
   input  logic             clr_all_i,
   input  logic [ROW_W-1:0] clr_row_i,
   output logic             clr_ready_o,
   output logic             fill_slot_o,
   output logic [ROW_W-1:0] crow_o,
   output logic [COL_W-1:0] ccol_o,
   output logic             clr_busy_o,
   output logic             clr_done_o
);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   clr_state_e       state_q, state_d;
   logic [ROW_W-1:0] crow_q, crow_d;
   logic [ROW_W-1:0] crow_last_q, crow_last_d;
   logic [COL_W-1:0] ccol_q, ccol_d;
   logic             done_q, done_d;
   logic             accept_s;

   // A host write in IDLE takes precedence over a clear request.
   assign clr_ready_o = (state_q == IDLE) && !wr_valid_i;
   assign accept_s    = clr_valid_i && clr_ready_o;
   assign fill_slot_o = (state_q == CLEAR) && !vid_valid_i;
   assign crow_o      = crow_q;
   assign ccol_o      = ccol_q;
   assign clr_busy_o  = (state_q == CLEAR);
   assign clr_done_o  = done_q;

   // State, counters and done pulse register; reset abandons any clear in flight.
   always_ff @(posedge clk or negedge reset_low) begin
      if (!reset_low) begin
         state_q     <= IDLE;
         crow_q      <= '0;
         crow_last_q <= '0;
         ccol_q      <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         crow_q      <= crow_d;
         crow_last_q <= crow_last_d;
         ccol_q      <= ccol_d;
         done_q      <= done_d;
      end
   end

   // Next-state logic: accept a clear, then advance the fill cursor on free cycles.
   always_comb begin
      state_d     = state_q;
      crow_d      = crow_q;
      crow_last_d = crow_last_q;
      ccol_d      = ccol_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               if (!clr_all_i && (clr_row_i > ROW_LAST)) begin
                  // Off-screen row: acknowledge with a done pulse, write nothing.
                  done_d = 1'b1;
               end else begin
                  crow_d      = clr_all_i ? '0 : clr_row_i;
                  crow_last_d = clr_all_i ? ROW_LAST : clr_row_i;
                  ccol_d      = '0;
                  state_d     = CLEAR;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CLEAR: begin
            if (!vid_valid_i) begin
               if (ccol_q == COL_LAST) begin
                  ccol_d = '0;
                  if (crow_q == crow_last_q) begin
                     // Row counter stays put so it never runs past the last row.
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     crow_d = crow_q + ROW_W'(1);
                  end
               end else begin
                  ccol_d = ccol_q + COL_W'(1);
               end
            end else begin
               state_d = CLEAR;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port text VRAM arbiter: video reads > host writes > clear engine.
module vram_arbiter
   import vt4_vram_pkg::*;
#(
   parameter int         ROWS      = DEF_ROWS,
   parameter int         COLS      = DEF_COLS,
   parameter logic [7:0] FILL_CHAR = DEF_FILL_CHAR
) (
   input  logic              clk,
   input  logic              reset_low,
   input  logic              vid_valid,
   input  logic [ROW_W-1:0]  vid_row,
   input  logic [COL_W-1:0]  vid_col,
   output logic [7:0]        vid_byte,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ROW_W-1:0]  wr_row,
   input  logic [COL_W-1:0]  wr_col,
   input  logic [7:0]        wr_byte,
   input  logic              clr_valid,
   output logic              clr_ready,
   input  logic              clr_all,
   input  logic [ROW_W-1:0]  clr_row,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   logic             fill_slot_s;
   logic [ROW_W-1:0] crow_s;
   logic [COL_W-1:0] ccol_s;
   logic             in_range_s;
   vram_addr_t       addr_s;

   vram_clear_engine #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_clear (
      .clk         (clk),
      .reset_low   (reset_low),
      .vid_valid_i (vid_valid),
      .wr_valid_i  (wr_valid),
      .clr_valid_i (clr_valid),
      .clr_all_i   (clr_all),
      .clr_row_i   (clr_row),
      .clr_ready_o (clr_ready),
      .fill_slot_o (fill_slot_s),
      .crow_o      (crow_s),
      .ccol_o      (ccol_s),
      .clr_busy_o  (clr_busy),
      .clr_done_o  (clr_done)
   );

   // Host writes are shut out for the whole clear and in any video cycle.
   assign wr_ready   = !vid_valid && !clr_busy;
   assign in_range_s = cell_in_range(wr_row, wr_col, ROW_LAST, COL_LAST);
   assign vid_byte   = mem_rdata;
   assign mem_addr   = addr_s;

   // Priority mux onto the VRAM port; out-of-range host writes are handshaken but dropped.
   always_comb begin
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      addr_s     = '0;
      mem_wdata  = 8'h00;
      if (vid_valid) begin
         mem_en     = 1'b1;
         addr_s.row = vid_row;
         addr_s.col = vid_col;
      end else if (wr_valid && wr_ready) begin
         mem_en     = in_range_s;
         mem_we     = in_range_s;
         addr_s.row = wr_row;
         addr_s.col = wr_col;
         mem_wdata  = wr_byte;
      end else if (fill_slot_s) begin
         mem_en     = 1'b1;
         mem_we     = 1'b1;
         addr_s.row = crow_s;
         addr_s.col = ccol_s;
         mem_wdata  = FILL_CHAR;
      end else begin
         mem_en = 1'b0;
         mem_we = 1'b0;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: expected VRAM writes are queued as
// stimulus is driven and popped as the port performs them.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        reset_low;
   logic        vid_valid;
   logic [4:0]  vid_row;
   logic [6:0]  vid_col;
   logic [7:0]  vid_byte;
   logic        wr_valid;
   logic        wr_ready;
   logic [4:0]  wr_row;
   logic [6:0]  wr_col;
   logic [7:0]  wr_byte;
   logic        clr_valid;
   logic        clr_ready;
   logic        clr_all;
   logic [4:0]  clr_row;
   logic        clr_busy;
   logic        clr_done;
   logic        mem_en;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  data;
   } wexp_t;

   wexp_t      exp_q[$];
   wexp_t      mon_e;
   int         n_checks = 0;
   int         n_fail   = 0;
   int         wr_cnt   = 0;
   logic [7:0] vram [0:4095];
   logic [7:0] rdata_q;

   always #5 clk = ~clk;

   vram_arbiter dut (
      .clk       (clk),
      .reset_low (reset_low),
      .vid_valid (vid_valid),
      .vid_row   (vid_row),
      .vid_col   (vid_col),
      .vid_byte  (vid_byte),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_row    (wr_row),
      .wr_col    (wr_col),
      .wr_byte   (wr_byte),
      .clr_valid (clr_valid),
      .clr_ready (clr_ready),
      .clr_all   (clr_all),
      .clr_row   (clr_row),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Synchronous single-port VRAM model with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_en === 1'b1) begin
         if (mem_we === 1'b1) vram[mem_addr] <= mem_wdata;
         else                 rdata_q <= vram[mem_addr];
      end
   end
   assign mem_rdata = rdata_q;

   // Port monitor: video cycles must be reads, every write must match the scoreboard.
   always @(negedge clk) begin
      if (reset_low === 1'b1 && vid_valid === 1'b1) begin
         n_checks++;
         if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== {vid_row, vid_col}) begin
            n_fail++;
            $display("FAIL vid_slot: en=%b we=%b addr=%h, required en=1 we=0 addr=%h",
                     mem_en, mem_we, mem_addr, {vid_row, vid_col});
         end
      end
      if (mem_en === 1'b1 && mem_we === 1'b1) begin
         wr_cnt++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
               n_fail++;
               $display("FAIL write_order: addr=%h data=%h, required addr=%h data=%h",
                        mem_addr, mem_wdata, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   // Queue the 100 fill writes of one row.
   task automatic push_fill(input int r, input int ncols);
      logic [4:0] rr;
      logic [6:0] cc;
      rr = r[4:0];
      for (int c = 0; c < ncols; c++) begin
         cc = c[6:0];
         exp_q.push_back({rr, cc, 8'h20});
      end
   endtask

   // Wait (bounded) for the done pulse; reports busy cycles seen before it.
   task automatic wait_done(output bit seen, output int busy, output logic busy_at_done);
      seen = 1'b0;
      busy = 0;
      busy_at_done = 1'bx;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (clr_done === 1'b1) begin
            seen = 1'b1;
            busy_at_done = clr_busy;
         end else if (clr_busy === 1'b1) begin
            busy++;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", clr_busy); end
      n_checks++;
      if (clr_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", clr_done); end
      n_checks++;
      if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b, required 0", mem_en); end
      @(posedge clk); #1 reset_low = 1'b1;
      @(negedge clk);
      n_checks++;
      if (clr_ready !== 1'b1 || wr_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: clr_ready=%b wr_ready=%b, required 1 1", clr_ready, wr_ready);
      end
   endtask

   task automatic test_host_write();
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_row = 5'd2; wr_col = 7'd5; wr_byte = 8'h41;
      exp_q.push_back({12'h105, 8'h41});
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h105 || mem_wdata !== 8'h41) begin
         n_fail++;
         $display("FAIL host_write: ready=%b we=%b addr=%h data=%h, required 1 1 105 41",
                  wr_ready, mem_we, mem_addr, mem_wdata);
      end
      @(posedge clk); #1 wr_col = 7'd100;
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b1 || mem_we !== 1'b0) begin
         n_fail++; $display("FAIL host_col_oob: ready=%b we=%b, required 1 0", wr_ready, mem_we);
      end
      @(posedge clk); #1 wr_row = 5'd30; wr_col = 7'd0;
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b1 || mem_we !== 1'b0) begin
         n_fail++; $display("FAIL host_row_oob: ready=%b we=%b, required 1 0", wr_ready, mem_we);
      end
      @(posedge clk); #1 wr_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [6:0] cc;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         cc = i[6:0];
         wr_valid = 1'b1; wr_row = 5'd10; wr_col = cc; wr_byte = 8'h60 + 8'(i);
         exp_q.push_back({5'd10, cc, 8'h60 + 8'(i)});
         @(negedge clk);
         n_checks++;
         if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b, required 1", i, wr_ready); end
      end
      @(posedge clk); #1 wr_valid = 1'b0;
   endtask

   task automatic test_video_priority();
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_row = 5'd3; wr_col = 7'd7; wr_byte = 8'h5A;
      exp_q.push_back({12'h187, 8'h5A});
      @(posedge clk); #1;
      vid_valid = 1'b1; vid_row = 5'd3; vid_col = 7'd7;
      wr_col = 7'd8; wr_byte = 8'h77;
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 12'h187) begin
         n_fail++; $display("FAIL vid_priority: ready=%b we=%b addr=%h, required 0 0 187", wr_ready, mem_we, mem_addr);
      end
      @(posedge clk); #1;
      vid_valid = 1'b0;
      exp_q.push_back({12'h188, 8'h77});
      @(negedge clk);
      n_checks++;
      if (vid_byte !== 8'h5A) begin n_fail++; $display("FAIL vid_byte: got %h, required 5a", vid_byte); end
      n_checks++;
      if (wr_ready !== 1'b1 || mem_addr !== 12'h188) begin
         n_fail++; $display("FAIL write_after_vid: ready=%b addr=%h, required 1 188", wr_ready, mem_addr);
      end
      @(posedge clk); #1 wr_valid = 1'b0;
   endtask

   task automatic test_row_clear();
      int   base, busy;
      bit   seen;
      logic bad;
      base = wr_cnt;
      @(posedge clk); #1;
      clr_valid = 1'b1; clr_all = 1'b0; clr_row = 5'd4;
      push_fill(4, 100);
      @(negedge clk);
      n_checks++;
      if (clr_ready !== 1'b1) begin n_fail++; $display("FAIL row_clr_ready: got %b, required 1", clr_ready); end
      @(posedge clk); #1 clr_valid = 1'b0;
      wait_done(seen, busy, bad);
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL row_clr_done: no done pulse within bound"); end
      n_checks++;
      if (bad !== 1'b0) begin n_fail++; $display("FAIL row_clr_busy_at_done: got %b, required 0", bad); end
      n_checks++;
      if (busy != 100) begin n_fail++; $display("FAIL row_clr_cycles: got %0d, required 100", busy); end
      n_checks++;
      if (wr_cnt - base != 100) begin n_fail++; $display("FAIL row_clr_writes: got %0d, required 100", wr_cnt - base); end
      @(negedge clk);
      n_checks++;
      if (clr_done !== 1'b0) begin n_fail++; $display("FAIL row_clr_pulse: done=%b second cycle, required 0", clr_done); end
   endtask

   task automatic test_full_clear();
      int base, cycles;
      bit ready_seen, fin;
      base = wr_cnt; cycles = 0; ready_seen = 1'b0; fin = 1'b0;
      @(posedge clk); #1;
      clr_valid = 1'b1; clr_all = 1'b1;
      for (int r = 0; r < 30; r++) push_fill(r, 100);
      @(negedge clk);
      n_checks++;
      if (clr_ready !== 1'b1) begin n_fail++; $display("FAIL full_clr_ready: got %b, required 1", clr_ready); end
      for (int i = 0; i < 7000; i++) begin
         @(posedge clk); #1;
         clr_valid = 1'b0; clr_all = 1'b0;
         if (clr_busy !== 1'b1) begin
            fin = 1'b1;
            break;
         end
         cycles++;
         vid_valid = ~vid_valid; vid_row = 5'd1; vid_col = 7'd2;
         wr_valid = 1'b1; wr_row = 5'd1; wr_col = 7'd1; wr_byte = 8'hEE;
         @(negedge clk);
         if (wr_ready === 1'b1) ready_seen = 1'b1;
      end
      wr_valid = 1'b0; vid_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (clr_done !== 1'b1) begin n_fail++; $display("FAIL full_clr_done: got %b, required 1", clr_done); end
      n_checks++;
      if (!fin) begin n_fail++; $display("FAIL full_clr_timeout: still busy after 7000 cycles"); end
      n_checks++;
      if (cycles != 6000) begin n_fail++; $display("FAIL full_clr_cycles: got %0d, required 6000", cycles); end
      n_checks++;
      if (ready_seen) begin n_fail++; $display("FAIL full_clr_host_blocked: wr_ready=1 during clear, required 0"); end
      n_checks++;
      if (wr_cnt - base != 3000) begin n_fail++; $display("FAIL full_clr_writes: got %0d, required 3000", wr_cnt - base); end
   endtask

   task automatic test_simultaneous();
      int   busy;
      bit   seen;
      logic bad;
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_row = 5'd1; wr_col = 7'd1; wr_byte = 8'h33;
      clr_valid = 1'b1; clr_all = 1'b0; clr_row = 5'd5;
      exp_q.push_back({12'h081, 8'h33});
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b1 || clr_ready !== 1'b0) begin
         n_fail++; $display("FAIL simul_arb: wr_ready=%b clr_ready=%b, required 1 0", wr_ready, clr_ready);
      end
      @(posedge clk); #1;
      wr_valid = 1'b0;
      push_fill(5, 100);
      @(negedge clk);
      n_checks++;
      if (clr_ready !== 1'b1) begin n_fail++; $display("FAIL simul_clr_next: got %b, required 1", clr_ready); end
      @(posedge clk); #1 clr_valid = 1'b0;
      wait_done(seen, busy, bad);
      n_checks++;
      if (!seen || busy != 100) begin
         n_fail++; $display("FAIL simul_clr_run: done=%b busy=%0d, required 1 100", seen, busy);
      end
   endtask

   task automatic test_noop_clear();
      @(posedge clk); #1;
      clr_valid = 1'b1; clr_all = 1'b0; clr_row = 5'd30;
      @(posedge clk); #1 clr_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (clr_done !== 1'b1 || clr_busy !== 1'b0) begin
         n_fail++; $display("FAIL noop_clr: done=%b busy=%b, required 1 0", clr_done, clr_busy);
      end
      @(negedge clk);
      n_checks++;
      if (clr_done !== 1'b0) begin n_fail++; $display("FAIL noop_clr_pulse: got %b, required 0", clr_done); end
   endtask

   task automatic test_reset_mid_clear();
      int   base, busy;
      bit   seen, reached;
      logic bad;
      base = wr_cnt; reached = 1'b0;
      @(posedge clk); #1;
      clr_valid = 1'b1; clr_all = 1'b0; clr_row = 5'd6;
      push_fill(6, 50);
      @(posedge clk); #1 clr_valid = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (wr_cnt - base >= 50) begin
            reached = 1'b1;
            break;
         end
      end
      #1 reset_low = 1'b0;
      @(negedge clk);
      n_checks++;
      if (!reached) begin n_fail++; $display("FAIL rst_mid_progress: 50 fill writes not seen"); end
      n_checks++;
      if (clr_busy !== 1'b0 || clr_done !== 1'b0 || mem_en !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_state: busy=%b done=%b en=%b, required 0 0 0", clr_busy, clr_done, mem_en);
      end
      @(posedge clk); #1 reset_low = 1'b1;
      @(negedge clk);
      n_checks++;
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_no_done: done=%b busy=%b, required 0 0", clr_done, clr_busy);
      end
      n_checks++;
      if (wr_cnt - base != 50) begin n_fail++; $display("FAIL rst_mid_writes: got %0d, required 50", wr_cnt - base); end
      @(posedge clk); #1;
      clr_valid = 1'b1;
      push_fill(6, 100);
      @(posedge clk); #1 clr_valid = 1'b0;
      wait_done(seen, busy, bad);
      n_checks++;
      if (!seen || busy != 100) begin
         n_fail++; $display("FAIL rst_mid_restart: done=%b busy=%0d, required 1 100", seen, busy);
      end
   endtask

   // Hard time limit so the run can never hang.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Test sequence.
   initial begin
      reset_low = 1'b0;
      vid_valid = 1'b0; vid_row = 5'd0; vid_col = 7'd0;
      wr_valid = 1'b0; wr_row = 5'd0; wr_col = 7'd0; wr_byte = 8'h00;
      clr_valid = 1'b0; clr_all = 1'b0; clr_row = 5'd0;
      repeat (3) @(posedge clk);
      test_reset();
      test_host_write();
      test_back_to_back();
      test_video_priority();
      test_row_clear();
      test_full_clear();
      test_simultaneous();
      test_noop_clear();
      test_reset_mid_clear();
      @(posedge clk); #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Owns the single port of the 8-bit text VRAM (ROWS x COLS character cells, addressed {row, col}).
- Shares the port between three users:
  - the HDMI scan-out reader, which has fixed one-cycle latency and absolute priority and is never stalled;
  - a host character-write port with a valid/ready handshake;
  - an internal clear engine that fills one row or the whole screen with FILL_CHAR.
- Sits between the terminal/CPU logic, the HDMI text pipeline and the VRAM block RAM.

Parameters:
- ROWS, 30, number of text rows; rows >= ROWS are out of range.
- COLS, 100, number of text columns; cols >= COLS are out of range.
- FILL_CHAR, 8'h20, byte written by the clear engine.

Ports:
- clk  input  1  system/pixel clock
- reset_low  input  1  asynchronous active-low reset
- vid_valid  input  1  HDMI read request this cycle
- vid_row  input  5  HDMI read row
- vid_col  input  7  HDMI read column
- vid_byte  output  8  read data, valid the cycle after vid_valid; combinational pass-through of mem_rdata
- wr_valid  input  1  host write request
- wr_ready  output  1  host write accepted when wr_valid & wr_ready
- wr_row  input  5  host write row
- wr_col  input  7  host write column
- wr_byte  input  8  host write data
- clr_valid  input  1  clear request
- clr_ready  output  1  clear accepted when clr_valid & clr_ready
- clr_all  input  1  1 = clear whole screen, 0 = clear row clr_row only
- clr_row  input  5  row to clear when clr_all = 0
- clr_busy  output  1  clear engine active
- clr_done  output  1  one-cycle pulse after the last fill write
- mem_en  output  1  VRAM port enable
- mem_we  output  1  VRAM write enable
- mem_addr  output  12  {row[4:0], col[6:0]}
- mem_wdata  output  8  VRAM write data
- mem_rdata  input  8  VRAM synchronous read data (1-cycle latency)

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low, on reset_low.
  - On reset: state = IDLE; counters = 0; clr_busy = 0; clr_done = 0.
  - Reset asserted mid-clear abandons the clear. No completion pulse; partially filled rows remain.
- Port mux: combinational from the current inputs and registered state. Priority is video > host write > clear engine.
  - vid_valid = 1: mem_en = 1, mem_we = 0, mem_addr = {vid_row, vid_col}. No range check on video reads.
  - Host write accepted: mem_en = in_range, mem_we = in_range, mem_addr = {wr_row, wr_col}, mem_wdata = wr_byte.
    - in_range = (wr_row < ROWS) && (wr_col < COLS).
    - Out-of-range writes are accepted and silently dropped.
  - Clear engine slot: mem_en = 1, mem_we = 1, mem_addr = {crow, ccol}, mem_wdata = FILL_CHAR.
  - Otherwise mem_en = 0, mem_we = 0. mem_addr and mem_wdata are don't-care.
- wr_ready = !vid_valid && state == IDLE. Host writes are blocked for the whole of a clear.
- clr_ready = state == IDLE && !wr_valid. A host write in IDLE wins over a simultaneous clear request.
- State machine IDLE -> CLEAR -> IDLE:
  - IDLE, on clear accept:
    - crow = clr_all ? 0 : clr_row;
    - crow_last = clr_all ? ROWS-1 : clr_row;
    - ccol = 0;
    - go to CLEAR; clr_busy = 1 from the next cycle.
  - IDLE, clr_row >= ROWS with clr_all = 0: request is accepted as a no-op. Stay in IDLE; clr_done pulses next cycle.
  - CLEAR, each cycle with vid_valid = 0: issue the fill write, then
    - if ccol == COLS-1: ccol = 0 and crow++;
    - else ccol++.
  - CLEAR, cycle with vid_valid = 1: stall; counters hold.
  - CLEAR, fill write at crow == crow_last and ccol == COLS-1: go to IDLE; clr_busy = 0 and clr_done = 1 on the next cycle.
- Clear duration: a single-row clear with no video contention takes exactly COLS = 100 write cycles. A full clear takes ROWS*COLS = 3000.
- Column counter is 7 bits and row counter is 5 bits. They never pass COLS-1 or ROWS-1.
- Host write latency: the write commits in the handshake cycle. Back-to-back writes are allowed at one per cycle.

Decomposition:
- Package vt4_vram_pkg holds:
  - ROW_W = 5, COL_W = 7, ADDR_W = 12;
  - the default ROWS/COLS;
  - the typedef vram_addr_t as a packed struct {row, col};
  - the state enum {IDLE, CLEAR}.
- One natural sub-module: vram_clear_engine (row/col counters, the state machine, busy/done). The arbiter keeps only the priority mux and the ready logic.

Test Plan:
- Video priority: vid_valid = 1 with row 3, col 7 while wr_valid = 1 -> wr_ready = 0; mem_addr = 0x187 read; vid_byte equals mem_rdata next cycle. The write completes the first cycle vid_valid = 0.
- Host write: wr_valid = 1, row 2, col 5, byte 0x41, no video -> same cycle mem_we = 1, mem_addr = 0x105, mem_wdata = 0x41. Out-of-range col 100 -> wr_ready = 1 but mem_we = 0.
- Row clear: clr_all = 0, clr_row = 4, no video -> exactly 100 writes of 0x20 to addresses 0x200..0x263. clr_done pulses once; clr_busy is low again the same cycle.
- Full clear with contention: clr_all = 1, vid_valid toggling every other cycle -> 3000 fill writes, none in video cycles, completing in 6000 cycles. Host writes are refused throughout.
- Simultaneous requests: wr_valid and clr_valid in the same IDLE cycle -> the write is accepted and clr_ready = 0. The clear is accepted on the next cycle once wr_valid drops.
- Reset mid-clear: assert reset_low = 0 after 50 fill writes -> state returns to IDLE, clr_busy = 0, no clr_done. A new clear after reset runs from col 0.
